// File: rtl/msi_sched_pkg.sv
// Shared types and widths for the MSI scheduler block.
package msi_sched_pkg;
  localparam int MSI_NUM_W = 5;
  localparam int MSI_TC_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;
endpackage

// File: rtl/msi_scheduler_if.sv
// MSI request/ack handshake towards the HIP; the scheduler drives it as master.
interface msi_scheduler_if;
  import msi_sched_pkg::*;

  logic                 app_msi_req;
  logic [MSI_NUM_W-1:0] app_msi_num;
  logic [MSI_TC_W-1:0]  app_msi_tc;
  logic                 app_msi_ack;

  modport master (output app_msi_req, app_msi_num, app_msi_tc, input app_msi_ack);
  modport slave  (input app_msi_req, app_msi_num, app_msi_tc, output app_msi_ack);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping to 0.
module rr_arbiter
  import msi_sched_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [MSI_NUM_W-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [MSI_NUM_W-1:0] idx_o,
  output logic                 vld_o
);

  // Scan from the farthest candidate down to ptr_i so the nearest hit is assigned last.
  always_comb begin
    int i;
    i     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      i = int'(ptr_i) + k;
      if (i >= N) i = i - N;
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = MSI_NUM_W'(i);
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_scheduler.sv
// Coalesces per-source interrupt pulses into round-robin MSI requests with a 2-cycle inter-request gap.
// Define MSI_SCHED_TIMEOUT_EN to abandon a request after TIMEOUT_CYC clocks without ack.
module msi_scheduler
  import msi_sched_pkg::*;
#(
  parameter int                  N_SRC       = 8,
  parameter logic [MSI_TC_W-1:0] MSI_TC      = 3'd0,
  parameter int                  TIMEOUT_CYC = 1024
) (
  input  logic             pld_clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [N_SRC-1:0] src_en,
  input  logic             msi_en,
  msi_scheduler_if.master  msi,
  output logic [N_SRC-1:0] pend,
  output logic             busy,
  output logic             timeout_err
);

  if (N_SRC < 1 || N_SRC > 32 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("msi_scheduler: N_SRC must be 1..32 and TIMEOUT_CYC >= 1");
  end

  state_e               state_q, state_d;
  logic [N_SRC-1:0]     pend_q, pend_d;
  logic [N_SRC-1:0]     win_q, win_d;
  logic [MSI_NUM_W-1:0] ptr_q, ptr_d;
  logic [MSI_NUM_W-1:0] num_q, num_d;
  logic [N_SRC-1:0]     arb_gnt;
  logic [MSI_NUM_W-1:0] arb_idx;
  logic                 arb_vld;
  logic                 ack_fire;
  logic                 tmo_fire;

  rr_arbiter #(.N(N_SRC)) u_rr_arbiter (
    .req_i (pend_q & src_en),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign ack_fire = (state_q == REQ) && msi.app_msi_ack;

`ifdef MSI_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             terr_q;

  // Fires on the edge that completes TIMEOUT_CYC clocks in REQ; ack wins a tie.
  assign tmo_fire = (state_q == REQ) && !msi.app_msi_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pld_clk_clk) begin
    if (!reset_reset_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= (state_q == REQ && !tmo_fire && !ack_fire) ? cnt_q + 1'b1 : '0;
      terr_q <= tmo_fire;
    end
  end

  assign timeout_err = terr_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge pld_clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_vld && msi_en) state_d = REQ;
      REQ:     if (ack_fire || tmo_fire) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pulse landing on the ack edge re-arms the winner instead of being cleared away.
  always_comb begin
    pend_d = pend_q | src_irq;
    win_d  = win_q;
    num_d  = num_q;
    ptr_d  = ptr_q;
    if (ack_fire) pend_d = (pend_q & ~win_q) | src_irq;
    if (ack_fire || tmo_fire)
      ptr_d = (num_q == MSI_NUM_W'(N_SRC - 1)) ? '0 : num_q + 1'b1;
    if (state_q == IDLE && state_d == REQ) begin
      win_d = arb_gnt;
      num_d = arb_idx;
    end
  end

  always_comb begin
    msi.app_msi_req = (state_q == REQ);
    msi.app_msi_num = num_q;
    msi.app_msi_tc  = MSI_TC;
    pend            = pend_q;
    busy            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_msi_scheduler.sv
// Directed bench for msi_scheduler: latency, fairness, coalescing, masking, stability, reset and timeout.
module tb_msi_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src_irq;
  logic [7:0] src_en;
  logic       msi_en;
  logic [7:0] pend;
  logic       busy;
  logic       terr;
  int         n_chk  = 0;
  int         n_fail = 0;

  msi_scheduler_if msi_if ();

  msi_scheduler #(.N_SRC(8), .MSI_TC(3'd0), .TIMEOUT_CYC(16)) dut (
    .pld_clk_clk   (clk),
    .reset_reset_n (rst_n),
    .src_irq       (src_irq),
    .src_en        (src_en),
    .msi_en        (msi_en),
    .msi           (msi_if),
    .pend          (pend),
    .busy          (busy),
    .timeout_err   (terr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int hold;
    int terr_seen;
    rst_n = 1'b0; src_irq = '0; src_en = 8'hFF; msi_en = 1'b1;
    msi_if.app_msi_ack = 1'b0;

    // Reset state
    step(2);
    chk("rst_req", msi_if.app_msi_req, 0);
    chk("rst_num", msi_if.app_msi_num, 0);
    chk("rst_pend", pend, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", terr, 0);
    chk("tc", msi_if.app_msi_tc, 0);
    rst_n = 1'b1;
    step(1);

    // Single event: req two clocks after the pulse, dropped the clock after ack
    src_irq = 8'h08;
    step(1);
    src_irq = '0;
    chk("se_pend", pend, 8'h08);
    chk("se_req_early", msi_if.app_msi_req, 0);
    step(1);
    chk("se_req", msi_if.app_msi_req, 1);
    chk("se_num", msi_if.app_msi_num, 3);
    chk("se_busy", busy, 1);
    step(2);
    chk("se_hold_req", msi_if.app_msi_req, 1);
    chk("se_hold_num", msi_if.app_msi_num, 3);
    msi_if.app_msi_ack = 1'b1;
    step(1);
    msi_if.app_msi_ack = 1'b0;
    chk("se_ack_req", msi_if.app_msi_req, 0);
    chk("se_ack_pend", pend, 0);
    chk("se_gap_busy", busy, 1);
    step(1);
    chk("se_idle_busy", busy, 0);

    // Fairness from rr_ptr=0 with all pending
    do_reset();
    msi_en = 1'b0;
    src_irq = 8'hFF;
    step(1);
    src_irq = '0;
    chk("rr_pend", pend, 8'hFF);
    chk("rr_gated", msi_if.app_msi_req, 0);
    msi_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      step(1);
      chk($sformatf("rr_req%0d", v), msi_if.app_msi_req, 1);
      chk($sformatf("rr_num%0d", v), msi_if.app_msi_num, v);
      msi_if.app_msi_ack = 1'b1;
      step(1);
      msi_if.app_msi_ack = 1'b0;
      chk($sformatf("rr_drop%0d", v), msi_if.app_msi_req, 0);
      chk($sformatf("rr_pend%0d", v), pend, 32'hFF & ~((32'd2 << v) - 1));
      step(1);
      chk($sformatf("rr_gap%0d", v), msi_if.app_msi_req, 0);
    end
    chk("rr_idle", busy, 0);

    // Coincident pulse on ack re-arms vector 2; masked vector 5 is never served
    src_en = 8'hDF;
    msi_en = 1'b0;
    src_irq = 8'h24;
    step(1);
    src_irq = '0;
    msi_en = 1'b1;
    step(1);
    chk("co_num1", msi_if.app_msi_num, 2);
    chk("co_req1", msi_if.app_msi_req, 1);
    msi_if.app_msi_ack = 1'b1;
    src_irq = 8'h04;
    step(1);
    msi_if.app_msi_ack = 1'b0;
    src_irq = '0;
    chk("co_pend", pend, 8'h24);
    step(2);
    chk("co_req2", msi_if.app_msi_req, 1);
    chk("co_num2", msi_if.app_msi_num, 2);
    msi_if.app_msi_ack = 1'b1;
    step(1);
    msi_if.app_msi_ack = 1'b0;
    chk("mask_pend", pend, 8'h20);
    step(3);
    chk("mask_req", msi_if.app_msi_req, 0);
    chk("mask_busy", busy, 0);
    msi_if.app_msi_ack = 1'b1;
    step(1);
    msi_if.app_msi_ack = 1'b0;
    chk("stray_ack_pend", pend, 8'h20);
    chk("stray_ack_busy", busy, 0);

    // Enables dropped mid-REQ do not abort the handshake
    do_reset();
    src_en = 8'hFF;
    src_irq = 8'h40;
    step(1);
    src_irq = '0;
    step(1);
    chk("st_num", msi_if.app_msi_num, 6);
    msi_en = 1'b0;
    src_en = 8'h00;
    step(3);
    chk("st_hold_req", msi_if.app_msi_req, 1);
    chk("st_hold_num", msi_if.app_msi_num, 6);
    msi_if.app_msi_ack = 1'b1;
    step(1);
    msi_if.app_msi_ack = 1'b0;
    chk("st_drop", msi_if.app_msi_req, 0);
    chk("st_pend", pend, 0);
    msi_en = 1'b1;
    src_en = 8'hFF;
    step(2);

    // Reset mid-REQ drops req and loses pending events
    src_irq = 8'h12;
    step(1);
    src_irq = '0;
    step(1);
    chk("ra_num", msi_if.app_msi_num, 1);
    rst_n = 1'b0;
    step(1);
    chk("ra_req", msi_if.app_msi_req, 0);
    chk("ra_pend", pend, 0);
    chk("ra_busy", busy, 0);
    rst_n = 1'b1;
    step(1);

    // Unacknowledged request
    src_irq = 8'h80;
    step(1);
    src_irq = '0;
    step(1);
    chk("to_req", msi_if.app_msi_req, 1);
    chk("to_num", msi_if.app_msi_num, 7);
`ifdef MSI_SCHED_TIMEOUT_EN
    step(15);
    chk("to_req15", msi_if.app_msi_req, 1);
    chk("to_terr15", terr, 0);
    step(1);
    chk("to_req16", msi_if.app_msi_req, 0);
    chk("to_terr16", terr, 1);
    chk("to_pend", pend, 8'h80);
    step(1);
    chk("to_terr_pulse", terr, 0);
`else
    hold = 0;
    terr_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      step(1);
      if (msi_if.app_msi_req && msi_if.app_msi_num == 5'd7) hold++;
      if (terr) terr_seen++;
    end
    chk("to_hold1000", hold, 1000);
    chk("to_terr_never", terr_seen, 0);
    chk("to_pend", pend, 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msi_scheduler.md
MSI_SCHEDULER -- requirements
Module: msi_scheduler

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources (1..32); source i maps to MSI vector i.
REQ-002 Parameter MSI_TC, default 3'd0, traffic class driven on app_msi_tc.
REQ-003 Parameter TIMEOUT_CYC, default 1024, ack-wait limit in clocks (used only when MSI_SCHED_TIMEOUT_EN is defined).
REQ-004 Clocking and reset SHALL be one clock with a synchronous, active-low reset, named as follows.
REQ-005 pld_clk_clk  in  1  sole clock, the HIP application clock.
REQ-006 reset_reset_n  in  1  synchronous active-low reset.
REQ-007 src_irq  in  N_SRC  per-source one-cycle event pulse.
REQ-008 src_en  in  N_SRC  per-source arbitration enable mask.
REQ-009 msi_en  in  1  MSI enable decoded from the config space.
REQ-010 app_msi_req  out  1  MSI request to the HIP.
REQ-011 app_msi_num  out  5  MSI vector number.
REQ-012 app_msi_tc  out  3  MSI traffic class.
REQ-013 app_msi_ack  in  1  MSI acknowledge from the HIP.
REQ-014 pend  out  N_SRC  pending-event status.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 timeout_err  out  1  one-cycle pulse when an ack times out.

Function
REQ-017 An src_irq[i] pulse sampled at clock edge t SHALL set pend[i] after that edge; repeated pulses while pend[i] is set coalesce into one MSI.
REQ-018 The FSM SHALL have the states IDLE, REQ and GAP.
REQ-019 IDLE -> REQ when any (pend & src_en) bit is set and msi_en=1.
REQ-020 The winner SHALL be chosen round-robin: the first eligible index at or above rr_ptr, wrapping from N_SRC-1 to 0.
REQ-021 On entry to REQ, app_msi_req=1 and app_msi_num=winner SHALL be registered, so app_msi_req is asserted 2 clocks after the src_irq pulse when the FSM is idle.
REQ-022 In REQ, app_msi_req, app_msi_num and app_msi_tc SHALL be held stable until app_msi_ack=1.
REQ-023 On ack: app_msi_req=0 on the next clock, pend[winner] cleared, rr_ptr=(winner+1) mod N_SRC, and the FSM -> GAP.
REQ-024 GAP SHALL last exactly 1 clock with app_msi_req=0 and then go -> IDLE, giving a minimum 2-cycle gap between requests.
REQ-025 Simultaneous src_irq[winner] and app_msi_ack: pend[winner] SHALL remain set.
REQ-026 app_msi_ack outside REQ SHALL be ignored.
REQ-027 Deassertion of msi_en or src_en[winner] during REQ SHALL NOT abort the handshake.
REQ-028 Pending bits of masked sources SHALL be retained, and those sources are skipped by arbitration.
REQ-029 app_msi_tc SHALL equal MSI_TC constantly.

Reset
REQ-030 While reset_reset_n=0 at a clock edge: FSM=IDLE, pend=0, rr_ptr=0, app_msi_req=0, app_msi_num=0, busy=0, timeout_err=0, timeout counter=0.
REQ-031 Reset asserted mid-REQ SHALL drop app_msi_req on the next edge, and pending events are lost.

Configuration
REQ-032 With MSI_SCHED_TIMEOUT_EN defined, a counter SHALL run in REQ; when it reaches TIMEOUT_CYC without ack:
- app_msi_req deasserted;
- timeout_err pulsed for 1 clock;
- pend[winner] retained;
- rr_ptr advanced past the winner;
- FSM -> GAP.
REQ-033 Without MSI_SCHED_TIMEOUT_EN, REQ SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-034 A shared package msi_sched_pkg SHALL hold the state enum (IDLE/REQ/GAP), MSI_NUM_W=5 and MSI_TC_W=3.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (request vector + pointer in, one-hot grant + index out, combinational).

Verification
REQ-036 Single event: src_irq[3] pulse at cycle 10 with msi_en=1 -> app_msi_req=1 and app_msi_num=3 at cycle 12; ack at cycle 15 -> req=0 at cycle 16 and pend[3]=0.
REQ-037 Fairness: pend=8'hFF, rr_ptr=0, immediate acks -> vectors served in order 0,1,...,7, and the next request starts 2 cycles after each ack.
REQ-038 Coincidence and mask: src_irq[2] in the ack cycle of vector 2 -> a second MSI with num=2 follows; src_en[5]=0 -> vector 5 is never requested while pend[5] stays 1.
REQ-039 Stability and abort: msi_en dropped mid-REQ -> req/num held until ack; reset asserted mid-REQ -> req=0 and pend=0 next cycle.
REQ-040 Timeout (macro defined, TIMEOUT_CYC=16): no ack -> req drops and timeout_err pulses 16 cycles after req rises, and pend is retained; macro undefined -> req held for 1000 cycles.
